// File: rtl/enc_pkg.sv
// Shared types and code constants for the request encoder.
// Optional build macro: REQ_ENCODER_ROUND_ROBIN_EN (selects round-robin search in req_encoder).
package enc_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_e;

    // Inverse of the 2-to-4 decoder mapping, carried as {a,b}.
    localparam logic [1:0] CODE_Q1 = 2'b00;
    localparam logic [1:0] CODE_Q2 = 2'b01;
    localparam logic [1:0] CODE_Q3 = 2'b10;
    localparam logic [1:0] CODE_Q4 = 2'b11;

endpackage

// File: rtl/pri_pick.sv
// Combinational circular priority picker: first set bit of pend_i searching
// upward (mod 4) from start_i.
module pri_pick (
    input  logic [3:0] pend_i,
    input  logic [1:0] start_i,
    output logic [1:0] idx_o,
    output logic       found_o
);

    logic [1:0] k;

    // Walk offsets from farthest to nearest so the nearest hit is the last write.
    always_comb begin
        idx_o   = 2'b00;
        found_o = 1'b0;
        k       = 2'b00;
        for (int i = 3; i >= 0; i--) begin
            k = start_i + 2'(i);
            if (pend_i[k]) begin
                idx_o   = k;
                found_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/req_encoder.sv
// Four-line request encoder with pending latches and a valid/ready handshake.
// Optional build macro: REQ_ENCODER_ROUND_ROBIN_EN (search starts after last served index).
//
//   state   | meaning
//   IDLE    | no code presented; picks a pending index when any pend bit is set
//   PRESENT | {a,b} holds a code, valid=1, waiting for ready
module req_encoder
    import enc_pkg::*;
#(
    parameter int unsigned STICKY = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       q1,
    input  logic       q2,
    input  logic       q3,
    input  logic       q4,
    input  logic       ready,
    output logic       a,
    output logic       b,
    output logic       valid,
    output logic [3:0] pend,
    output logic       ovf
);

    state_e     state_q, state_d;
    logic [3:0] pend_q, pend_d;
    logic [1:0] code_q, code_d;
    logic       valid_q, valid_d;
    logic       ovf_q, ovf_d;
    logic [3:0] req, clr;
    logic [1:0] start_idx, pick_idx;
    logic       pick_found, hs;

`ifdef REQ_ENCODER_ROUND_ROBIN_EN
    logic [1:0] ptr_q, ptr_d;
    assign start_idx = ptr_q + 2'd1;
`else
    assign start_idx = CODE_Q1;
`endif

    assign req = {q4, q3, q2, q1};
    assign hs  = (state_q == PRESENT) && valid_q && ready;

    pri_pick u_pick (
        .pend_i  (pend_q),
        .start_i (start_idx),
        .idx_o   (pick_idx),
        .found_o (pick_found)
    );

    // A new request on the bit being cleared wins, so OR after masking.
    always_comb begin
        clr = 4'b0000;
        if (hs) begin
            clr[code_q] = 1'b1;
        end
        if (STICKY != 0) begin
            pend_d = (pend_q & ~clr) | req;
            ovf_d  = ovf_q | (|(req & pend_q & ~clr));
        end else begin
            pend_d = req;
            ovf_d  = ovf_q;
        end
    end

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        valid_d = valid_q;
`ifdef REQ_ENCODER_ROUND_ROBIN_EN
        ptr_d   = ptr_q;
`endif
        case (state_q)
            IDLE: begin
                valid_d = 1'b0;
                if (pick_found) begin
                    code_d  = pick_idx;
                    valid_d = 1'b1;
                    state_d = PRESENT;
                end
            end
            PRESENT: begin
                if (hs) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
`ifdef REQ_ENCODER_ROUND_ROBIN_EN
                    ptr_d   = code_q;
`endif
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pend_q  <= 4'b0000;
            code_q  <= CODE_Q1;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
`ifdef REQ_ENCODER_ROUND_ROBIN_EN
            ptr_q   <= CODE_Q4;
`endif
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            code_q  <= code_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
`ifdef REQ_ENCODER_ROUND_ROBIN_EN
            ptr_q   <= ptr_d;
`endif
        end
    end

    assign a     = code_q[1];
    assign b     = code_q[0];
    assign valid = valid_q;
    assign pend  = pend_q;
    assign ovf   = ovf_q;

endmodule
